// File: rtl/fft_in_pkg.sv
// Shared constants, bank state encoding and lane-vector type for the FFT frame loader.
// Q conjugation helper is used only when FFT_IN_CONJ_EN is defined.
package fft_in_pkg;
   localparam int WIDTH     = 9;
   localparam int NLANE     = 16;
   localparam int FRAME_LEN = 512;
   localparam int ROWS      = FRAME_LEN / NLANE;
   localparam int WBITS     = $clog2(FRAME_LEN);
   localparam int RBITS     = $clog2(ROWS);
   localparam int LBITS     = $clog2(NLANE);

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_st_e;

   typedef logic signed [WIDTH-1:0] sample_t;
   typedef sample_t lane_vec_t [NLANE];

   // Negation that clamps the most negative code to the most positive one.
   function automatic sample_t sat_neg(input sample_t x);
      if (x == {1'b1, {(WIDTH-1){1'b0}}})
         return {1'b0, {(WIDTH-1){1'b1}}};
      return -x;
   endfunction
endpackage

// File: rtl/fft_in_loader_if.sv
// Serial sample input and parallel FFT vector output of the frame loader.
// The fft_mode signal exists only when FFT_IN_CONJ_EN is defined.
interface fft_in_loader_if;
   import fft_in_pkg::*;

   sample_t   s_i;
   sample_t   s_q;
   logic      s_valid;
   logic      s_last;
   logic      s_ready;
`ifdef FFT_IN_CONJ_EN
   logic      fft_mode;
`endif
   lane_vec_t in_i;
   lane_vec_t in_q;
   logic      din_valid;
   logic      frame_start;
   logic      frame_err;

   modport master (
`ifdef FFT_IN_CONJ_EN
      output fft_mode,
`endif
      output s_i, s_q, s_valid, s_last,
      input  s_ready, in_i, in_q, din_valid, frame_start, frame_err
   );

   modport slave (
`ifdef FFT_IN_CONJ_EN
      input  fft_mode,
`endif
      input  s_i, s_q, s_valid, s_last,
      output s_ready, in_i, in_q, din_valid, frame_start, frame_err
   );
endinterface

// File: rtl/fft_in_bank.sv
// One 32-row x 16-lane complex frame bank: single-sample write port, full-row registered read.
// Each lane is its own RAM so a whole row can be read in one cycle.
module fft_in_bank
   import fft_in_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [LBITS-1:0] wlane,
   input  logic [RBITS-1:0] wrow,
   input  sample_t          wi,
   input  sample_t          wq,
   input  logic             re,
   input  logic [RBITS-1:0] rrow,
   output lane_vec_t        rd_i,
   output lane_vec_t        rd_q
);
   generate
      for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
         logic [2*WIDTH-1:0] mem [ROWS];
         logic [2*WIDTH-1:0] rd_reg;

         always_ff @(posedge clk) begin
            if (we && wlane == LBITS'(gi))
               mem[wrow] <= {wi, wq};
            if (re)
               rd_reg <= mem[rrow];
         end

         assign rd_i[gi] = rd_reg[2*WIDTH-1:WIDTH];
         assign rd_q[gi] = rd_reg[WIDTH-1:0];
      end
   endgenerate
endmodule

// File: rtl/fft_in_loader.sv
// Ping-pong frame loader: collects 512 serial samples per bank and replays each frame as a 32-row burst.
// Defining FFT_IN_CONJ_EN adds fft_mode, which conjugates (saturating Q negate) a whole frame at write time.
module fft_in_loader
   import fft_in_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,   // active-high asynchronous reset despite the name
   fft_in_loader_if.slave  bus
);
   bank_st_e         st_reg [2];
   logic             fptr_reg;
   logic [WBITS-1:0] wcnt_reg;
   logic             draining_reg;
   logic             dbank_reg;
   logic [RBITS-1:0] rcnt_reg;
   logic             rv_reg;
   logic             rfirst_reg;
   logic             rsel_reg;
   lane_vec_t        in_i_reg;
   lane_vec_t        in_q_reg;
   logic             din_valid_reg;
   logic             frame_start_reg;
   logic             frame_err_reg;

   logic             s_ready;
   logic             accept;
   logic             last_slot;
   logic             start;
   logic             start_bank;
   logic             rd_en;
   logic [RBITS-1:0] rd_row;
   logic             rd_bank;
   sample_t          wq_data;
   lane_vec_t        rd_i [2];
   lane_vec_t        rd_q [2];

   assign s_ready   = !(st_reg[fptr_reg] == BANK_FULL || st_reg[fptr_reg] == BANK_DRAINING);
   assign accept    = bus.s_valid && s_ready;
   assign last_slot = (wcnt_reg == WBITS'(FRAME_LEN - 1));

   // If both banks are full the fill pointer has wrapped onto the older one.
   assign start      = !draining_reg && (st_reg[0] == BANK_FULL || st_reg[1] == BANK_FULL);
   assign start_bank = (st_reg[fptr_reg] == BANK_FULL) ? fptr_reg : ~fptr_reg;
   assign rd_en      = start || draining_reg;
   assign rd_row     = start ? '0 : rcnt_reg;
   assign rd_bank    = start ? start_bank : dbank_reg;

`ifdef FFT_IN_CONJ_EN
   logic mode_reg;
   logic mode_now;
   assign mode_now = (wcnt_reg == '0) ? bus.fft_mode : mode_reg;
   assign wq_data  = mode_now ? sat_neg(bus.s_q) : bus.s_q;
`else
   assign wq_data  = bus.s_q;
`endif

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         fft_in_bank u_bank (
            .clk   (clk),
            .we    (accept && fptr_reg == 1'(gi)),
            .wlane (wcnt_reg[WBITS-1 -: LBITS]),
            .wrow  (wcnt_reg[RBITS-1:0]),
            .wi    (bus.s_i),
            .wq    (wq_data),
            .re    (rd_en && rd_bank == 1'(gi)),
            .rrow  (rd_row),
            .rd_i  (rd_i[gi]),
            .rd_q  (rd_q[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         st_reg[0]       <= BANK_EMPTY;
         st_reg[1]       <= BANK_EMPTY;
         fptr_reg        <= 1'b0;
         wcnt_reg        <= '0;
         draining_reg    <= 1'b0;
         dbank_reg       <= 1'b0;
         rcnt_reg        <= '0;
         rv_reg          <= 1'b0;
         rfirst_reg      <= 1'b0;
         rsel_reg        <= 1'b0;
         in_i_reg        <= '{default: '0};
         in_q_reg        <= '{default: '0};
         din_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_err_reg   <= 1'b0;
`ifdef FFT_IN_CONJ_EN
         mode_reg        <= 1'b0;
`endif
      end else begin
         // Drain engine: the bank is released once its last row has been read out.
         if (start) begin
            draining_reg       <= 1'b1;
            dbank_reg          <= start_bank;
            rcnt_reg           <= RBITS'(1);
            st_reg[start_bank] <= BANK_DRAINING;
         end else if (draining_reg) begin
            rcnt_reg <= rcnt_reg + 1'b1;
            if (rcnt_reg == RBITS'(ROWS - 1)) begin
               draining_reg      <= 1'b0;
               st_reg[dbank_reg] <= BANK_EMPTY;
            end
         end
         rv_reg     <= rd_en;
         rfirst_reg <= start;
         rsel_reg   <= rd_bank;

         // Fill side; s_ready guarantees it never touches the draining bank.
         frame_err_reg <= 1'b0;
         if (accept) begin
`ifdef FFT_IN_CONJ_EN
            if (wcnt_reg == '0)
               mode_reg <= bus.fft_mode;
`endif
            if (bus.s_last && !last_slot) begin
               frame_err_reg    <= 1'b1;
               wcnt_reg         <= '0;
               st_reg[fptr_reg] <= BANK_EMPTY;
            end else if (last_slot) begin
               frame_err_reg    <= !bus.s_last;
               wcnt_reg         <= '0;
               st_reg[fptr_reg] <= BANK_FULL;
               fptr_reg         <= ~fptr_reg;
            end else begin
               wcnt_reg         <= wcnt_reg + 1'b1;
               st_reg[fptr_reg] <= BANK_FILLING;
            end
         end

         din_valid_reg   <= rv_reg;
         frame_start_reg <= rv_reg && rfirst_reg;
         if (rv_reg) begin
            in_i_reg <= rd_i[rsel_reg];
            in_q_reg <= rd_q[rsel_reg];
         end
      end
   end

   assign bus.s_ready     = s_ready;
   assign bus.in_i        = in_i_reg;
   assign bus.in_q        = in_q_reg;
   assign bus.din_valid   = din_valid_reg;
   assign bus.frame_start = frame_start_reg;
   assign bus.frame_err   = frame_err_reg;
endmodule
